muldiv_sequencer: RTL

- Multi-cycle MULT/MULTU/DIV/DIVU unit that sits beside the execute stage. It owns the HI/LO architectural registers.
- Sequences an iterative shift-add multiplier and a restoring divider, one bit per cycle.
- Stalls the pipeline while an operation runs. Serves MFHI/MFLO/MTHI/MTLO without stalling.

---
 rtl/muldiv_sequencer_pkg.sv | 36 +++
 rtl/muldiv_datapath.sv | 107 ++++++++++
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide unit: opcode/funct codes, FSM state
// encodings and operation types, alongside the other R-type codes of the decoder.
package muldiv_sequencer_pkg;

  localparam logic [5:0] OPC_RTYPE   = 6'h00;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_OR    = 6'h25;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Encoding matches funct[1:0] of MULT..DIVU so decode is a plain cast.
  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } md_op_e;

  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative engine: shift-add multiplier and restoring divider working on operand
// magnitudes, one bit per step, with sign fix-up of the final HI/LO results.
module muldiv_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  md_op_e            op,
  input  logic [DWIDTH-1:0] rs,
  input  logic [DWIDTH-1:0] rt,
  output logic [DWIDTH-1:0] hi_res,
  output logic [DWIDTH-1:0] lo_res,
  output logic              is_mul,
  output logic              div_zero,
  output logic              mul_rest_zero
);

  localparam int W = DWIDTH;

  md_op_e          op_q;
  logic [2*W-1:0]  acc;       // product, or {remainder, dividend/quotient}
  logic [2*W-1:0]  mcand;
  logic [W-1:0]    opb;       // multiplier (shifts right) or divisor
  logic [W-1:0]    rs_raw;
  logic            neg_lo;
  logic            neg_hi;
  logic            zero_div;

  logic            signed_op;
  logic            sign_a;
  logic            sign_b;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic [W:0]      shifted;
  logic [W+1:0]    diff;
  logic [2*W-1:0]  prod;

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] x, input logic en);
    return en ? (~x + W'(1)) : x;
  endfunction

  function automatic logic [2*W-1:0] neg_if_wide(input logic [2*W-1:0] x, input logic en);
    return en ? (~x + (2*W)'(1)) : x;
  endfunction

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign sign_a    = signed_op & rs[W-1];
  assign sign_b    = signed_op & rt[W-1];
  assign mag_a     = neg_if(rs, sign_a);
  assign mag_b     = neg_if(rt, sign_b);

  assign is_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign shifted   = acc[2*W-1:W-1];
  assign diff      = {1'b0, shifted} - {2'b00, opb};

  always_ff @(posedge clk) begin
    if (load) begin
      op_q     <= op;
      rs_raw   <= rs;
      zero_div <= (rt == '0);
      opb      <= mag_b;
      neg_lo   <= sign_a ^ sign_b;
      neg_hi   <= sign_a;
      if ((op == OP_MULT) || (op == OP_MULTU)) begin
        acc   <= '0;
        mcand <= {{W{1'b0}}, mag_a};
      end else begin
        acc   <= {{W{1'b0}}, mag_a};
        mcand <= '0;
      end
    end else if (step) begin
      if (is_mul) begin
        if (opb[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        opb   <= opb >> 1;
      end else if (!diff[W+1]) begin
        acc <= {diff[W-1:0], acc[W-2:0], 1'b1};
      end else begin
        acc <= {acc[2*W-2:0], 1'b0};
      end
    end
  end

  // Bits still to be consumed after this step; lets the sequencer cut a multiply short.
  assign mul_rest_zero = (opb[W-1:1] == '0);
  assign div_zero      = zero_div;
  assign prod          = neg_if_wide(acc, neg_lo);

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    if (is_mul) begin
      hi_res = prod[2*W-1:W];
      lo_res = prod[W-1:0];
    end else if (zero_div) begin
      hi_res = rs_raw;
      lo_res = '1;
    end else begin
      hi_res = neg_if(acc[2*W-1:W], neg_hi);
      lo_res = neg_if(acc[W-1:0], neg_lo);
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO: FSM, iteration counter, stall and flush.
// Optional build macro MULDIV_EARLY_OUT_EN ends multiplies once remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   md_i_ce,
  input  logic                   md_i_rtype,
  input  logic [FUNCT_WIDTH-1:0] md_i_funct,
  input  logic [DWIDTH-1:0]      md_i_data_rs,
  input  logic [DWIDTH-1:0]      md_i_data_rt,
  input  logic                   md_i_flush,
  output logic                   md_o_stall,
  output logic                   md_o_busy,
  output logic [DWIDTH-1:0]      md_o_hilo_value,
  output logic                   md_o_hilo_valid,
  output logic                   md_o_div_by_zero
);

  localparam int CNT_W = $clog2(DWIDTH + 1);
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  md_state_e         state;
  md_state_e         state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic [DWIDTH-1:0] hi;
  logic [DWIDTH-1:0] lo;
  logic [DWIDTH-1:0] hi_nx;
  logic [DWIDTH-1:0] lo_nx;
  logic              hi_we;
  logic              lo_we;

  logic [5:0]        funct6;
  logic              accept;
  logic              is_md;
  logic              is_mfhi;
  logic              is_mflo;
  logic              is_mthi;
  logic              is_mtlo;
  logic              load;
  logic              step;
  logic              last_calc;

  logic [DWIDTH-1:0] dp_hi;
  logic [DWIDTH-1:0] dp_lo;
  logic              dp_is_mul;
  logic              dp_div_zero;
  logic              dp_rest_zero;

  assign funct6  = md_i_funct[5:0];
  assign accept  = md_i_ce & md_i_rtype;
  assign is_md   = accept & is_muldiv_funct(funct6);
  assign is_mfhi = accept & (funct6 == FUNCT_MFHI);
  assign is_mflo = accept & (funct6 == FUNCT_MFLO);
  assign is_mthi = accept & (funct6 == FUNCT_MTHI);
  assign is_mtlo = accept & (funct6 == FUNCT_MTLO);

  assign last_calc = (cnt == CNT_W'(1)) || (EARLY_OUT && dp_is_mul && dp_rest_zero);

  muldiv_datapath #(
    .DWIDTH(DWIDTH)
  ) u_datapath (
    .clk          (clk),
    .load         (load),
    .step         (step),
    .op           (md_op_e'(funct6[1:0])),
    .rs           (md_i_data_rs),
    .rt           (md_i_data_rt),
    .hi_res       (dp_hi),
    .lo_res       (dp_lo),
    .is_mul       (dp_is_mul),
    .div_zero     (dp_div_zero),
    .mul_rest_zero(dp_rest_zero)
  );

  always_comb begin
    state_nx         = state;
    cnt_nx           = cnt;
    hi_nx            = hi;
    lo_nx            = lo;
    hi_we            = 1'b0;
    lo_we            = 1'b0;
    load             = 1'b0;
    step             = 1'b0;
    md_o_stall       = 1'b0;
    md_o_hilo_valid  = 1'b0;
    md_o_hilo_value  = '0;
    md_o_div_by_zero = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (is_mfhi) begin
            md_o_hilo_valid = 1'b1;
            md_o_hilo_value = hi;
          end else if (is_mflo) begin
            md_o_hilo_valid = 1'b1;
            md_o_hilo_value = lo;
          end
          if (!md_i_flush) begin
            if (is_md) begin
              md_o_stall = 1'b1;
              load       = 1'b1;
              cnt_nx     = CNT_W'(DWIDTH);
              state_nx   = ST_CALC;
            end
            if (is_mthi) begin
              hi_we = 1'b1;
              hi_nx = md_i_data_rs;
            end
            if (is_mtlo) begin
              lo_we = 1'b1;
              lo_nx = md_i_data_rs;
            end
          end
        end
        ST_CALC: begin
          md_o_stall = !md_i_flush;
          step       = 1'b1;
          cnt_nx     = cnt - CNT_W'(1);
          if (last_calc) state_nx = ST_FIX;
        end
        ST_FIX: begin
          // Pipeline advances on this edge; the instruction still on the inputs is retired, not re-issued.
          if (!md_i_flush) begin
            hi_we            = 1'b1;
            lo_we            = 1'b1;
            hi_nx            = dp_hi;
            lo_nx            = dp_lo;
            md_o_div_by_zero = !dp_is_mul && dp_div_zero;
          end
          state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
      if (md_i_flush) state_nx = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (hi_we) hi <= hi_nx;
      if (lo_we) lo <= lo_nx;
    end
  end

  assign md_o_busy = (state != ST_IDLE);

endmodule
